mac_tree_seq: RTL and testbench

- Sequencer for the 4-lane multiply-add tree: out = x0*w0 + x1*w1 + x2*w2 + x3*w3 + c, combinational, psum_bw result.
- Accepts a dot-product job of num_groups 4-element groups over a valid/ready stream.
- Registers each group onto the tree operands and feeds the running accumulator back as c.
- Returns the final psum over a valid/ready output. The tree is instantiated outside this block, alongside it in the tile.

---
 rtl/mac_tree_seq.sv | 121 ++++++++++++
 tb/tb_mac_tree_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tree_seq.sv
// Job sequencer for an external 4-lane multiply-add tree: streams groups onto the
// tree operands, feeds the running accumulator back as the tree's c input, returns the sum.
module mac_tree_seq #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [cnt_bw-1:0]   num_groups,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*bw-1:0]     x_in,
  input  logic [4*bw-1:0]     w_in,
  output logic [4*bw-1:0]     mac_x,
  output logic [4*bw-1:0]     mac_w,
  output logic [psum_bw-1:0]  mac_psum_in,
  input  logic [psum_bw-1:0]  mac_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [psum_bw-1:0]  out_psum
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [cnt_bw-1:0]   num_q, num_d;
  logic [cnt_bw-1:0]   count_q, count_d;
  logic [psum_bw-1:0]  acc_q, acc_d;
  logic                op_valid_q, op_valid_d;
  logic [4*bw-1:0]     x_q, x_d, w_q, w_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    num_d      = num_q;
    count_d    = count_q;
    acc_d      = acc_q;
    op_valid_d = op_valid_q;
    x_d        = x_q;
    w_d        = w_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_groups;
          acc_d      = '0;
          count_d    = '0;
          op_valid_d = 1'b0;
          state_d    = (num_groups == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        op_valid_d = accept;
        if (accept) begin
          x_d     = x_in;
          w_d     = w_in;
          count_d = count_q + cnt_bw'(1);
        end
        // The group registered last edge is on the tree now; fold its result.
        if (op_valid_q) begin
          acc_d = mac_out;
          if (count_q == num_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered, so derive them from the next state.
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == RUN) && (count_d < num_d);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      num_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      op_valid_q  <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      op_valid_q  <= op_valid_d;
      x_q         <= x_d;
      w_q         <= w_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign mac_x       = x_q;
  assign mac_w       = w_q;
  assign mac_psum_in = acc_q;
  assign out_psum    = acc_q;

endmodule

// File: tb/tb_mac_tree_seq.sv
// Bench for mac_tree_seq: models the external tree, drives jobs, and compares each
// result with the plain dot product of all groups taken modulo 2^16.
module tb_mac_tree_seq;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [7:0]  num_groups;
  logic [15:0] x_in, w_in, mac_x, mac_w;
  logic [15:0] mac_psum_in, mac_out, out_psum;
  logic        busy, in_ready, out_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] gx[$];
  logic [15:0] gw[$];

  always #5 clk = ~clk;

  mac_tree_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_groups(num_groups), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .mac_x(mac_x), .mac_w(mac_w), .mac_psum_in(mac_psum_in), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum)
  );

  // External multiply-add tree that lives beside the sequencer in the tile.
  function automatic logic [15:0] tree_eval(input logic [15:0] x, input logic [15:0] w,
                                            input logic [15:0] c);
    int s;
    s = int'(c);
    for (int i = 0; i < 4; i++) s += int'(x[4*i +: 4]) * int'(w[4*i +: 4]);
    return 16'(s);
  endfunction

  assign mac_out = tree_eval(mac_x, mac_w, mac_psum_in);

  // Reference: sum of every lane product of every queued group, wrapped to 16 bits.
  function automatic int ref_dot();
    longint s = 0;
    for (int g = 0; g < gx.size(); g++)
      for (int i = 0; i < 4; i++) s += longint'(gx[g][4*i +: 4]) * longint'(gw[g][4*i +: 4]);
    return int'(s % 65536);
  endfunction

  function automatic int exp_lat(input int n, input int gap);
    return (n == 0) ? 0 : (n - 1) * (gap + 1) + 2;
  endfunction

  function automatic int exp_ready(input int n, input int gap);
    return (n == 0) ? 0 : (n - 1) * (gap + 1) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job using gx/gw; lat counts edges after the start edge until out_valid.
  task automatic run_job(input int n, input int gap, input int stall, input bit pulse,
                         output int result, output int lat, output int ready_cycles,
                         output bit acc_stable, output bit out_stable,
                         output bit busy_after, output bit timed_out);
    int gi = 0, gapcnt = 0, budget;
    bit last_acc = 0, accepted;
    logic [15:0] pre;
    acc_stable = 1; out_stable = 1; timed_out = 0; ready_cycles = 0; lat = 0;
    start = 1; num_groups = 8'(n); tick();
    start = 0; num_groups = 8'($urandom);
    budget = n * (gap + 1) + 20;
    while (!out_valid && lat < budget) begin
      if (gi >= n) begin
        in_valid = 1; x_in = 16'($urandom); w_in = 16'($urandom);
      end else if (gapcnt == 0) begin
        in_valid = 1; x_in = gx[gi]; w_in = gw[gi];
      end else begin
        in_valid = 0; gapcnt--;
      end
      start = pulse && (gi == 1);
      if (in_ready) ready_cycles++;
      accepted = in_valid && in_ready;
      pre = out_psum;
      tick(); lat++;
      if (!last_acc && out_psum !== pre) acc_stable = 0;
      last_acc = accepted;
      if (accepted) begin gi++; gapcnt = gap; end
    end
    in_valid = 0; start = 0;
    timed_out = !out_valid;
    result = int'(out_psum);
    for (int k = 0; k < stall; k++) begin
      tick();
      if (out_valid !== 1'b1 || busy !== 1'b1 || int'(out_psum) != result) out_stable = 0;
    end
    out_ready = 1; tick(); out_ready = 0;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    vectors++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      miscompares++; $display("FAIL reset.flags got %b exp 000", {busy, in_ready, out_valid});
    end
    vectors++;
    if (out_psum !== 16'd0 || mac_psum_in !== 16'd0) begin
      miscompares++; $display("FAIL reset.acc got %0d/%0d exp 0/0", out_psum, mac_psum_in);
    end
    vectors++;
    if ({mac_x, mac_w} !== 32'd0) begin
      miscompares++; $display("FAIL reset.operands got %h exp 0", {mac_x, mac_w});
    end
  endtask

  task automatic test_single();
    int r, l, rc; bit as, os, ba, to;
    gx = '{16'h4321}; gw = '{16'h1111};
    run_job(1, 0, 0, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != 10) begin miscompares++; $display("FAIL single.result got %0d exp 10 timeout=%0b", r, to); end
    vectors++;
    if (l != 2) begin miscompares++; $display("FAIL single.latency got %0d exp 2", l); end
    vectors++;
    if (ba !== 1'b0) begin miscompares++; $display("FAIL single.busy_after got %b exp 0", ba); end
  endtask

  task automatic test_back_to_back();
    int r, l, rc; bit as, os, ba, to;
    gx = '{16'h4321, 16'hffff, 16'h0000}; gw = '{16'h2222, 16'hffff, 16'h0000};
    run_job(3, 0, 0, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != 920) begin miscompares++; $display("FAIL b2b.result got %0d exp 920 timeout=%0b", r, to); end
    vectors++;
    if (rc != 3) begin miscompares++; $display("FAIL b2b.in_ready_cycles got %0d exp 3", rc); end
    vectors++;
    if (l != 4) begin miscompares++; $display("FAIL b2b.latency got %0d exp 4", l); end
  endtask

  task automatic test_stall();
    int r, l, rc, e; bit as, os, ba, to;
    gx = '{16'($urandom), 16'($urandom)}; gw = '{16'($urandom), 16'($urandom)};
    e = ref_dot();
    run_job(2, 3, 5, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != e) begin miscompares++; $display("FAIL stall.result got %0d exp %0d timeout=%0b", r, e, to); end
    vectors++;
    if (!as) begin miscompares++; $display("FAIL stall.acc_in_gap got changed exp held"); end
    vectors++;
    if (!os) begin miscompares++; $display("FAIL stall.out_hold got unstable exp stable"); end
    vectors++;
    if (l != exp_lat(2, 3) || ba !== 1'b0) begin
      miscompares++; $display("FAIL stall.lat_busy got %0d/%b exp %0d/0", l, ba, exp_lat(2, 3));
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int r, l, rc, e; bit as, os, ba, to;
    gx.delete(); gw.delete();
    run_job(0, 0, 0, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != 0 || l != 0 || rc != 0) begin
      miscompares++; $display("FAIL zero.job got r=%0d lat=%0d rdy=%0d exp 0/0/0", r, l, rc);
    end
    gx = '{16'($urandom), 16'($urandom)}; gw = '{16'($urandom), 16'($urandom)};
    e = ref_dot();
    run_job(2, 1, 0, 1, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != e || l != exp_lat(2, 1)) begin
      miscompares++; $display("FAIL ignored_start got r=%0d lat=%0d exp %0d/%0d", r, l, e, exp_lat(2, 1));
    end
  endtask

  task automatic test_wrap();
    int r, l, rc; bit as, os, ba, to;
    gx.delete(); gw.delete();
    for (int g = 0; g < 73; g++) begin gx.push_back(16'hffff); gw.push_back(16'hffff); end
    run_job(73, 0, 0, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != 164) begin miscompares++; $display("FAIL wrap.result got %0d exp 164 timeout=%0b", r, to); end
    vectors++;
    if (l != 74) begin miscompares++; $display("FAIL wrap.latency got %0d exp 74", l); end
  endtask

  task automatic test_reset_mid_job();
    int r, l, rc; bit as, os, ba, to;
    start = 1; num_groups = 8'd4; tick(); start = 0;
    for (int g = 0; g < 2; g++) begin
      in_valid = 1; x_in = 16'($urandom); w_in = 16'($urandom); tick();
    end
    reset = 1; tick(); reset = 0; in_valid = 0;
    vectors++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_psum !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset.state got flags=%b acc=%0d exp 000/0", {busy, in_ready, out_valid}, out_psum);
    end
    gx = '{16'h4321}; gw = '{16'h1111};
    run_job(1, 0, 0, 0, r, l, rc, as, os, ba, to);
    vectors++;
    if (to || r != 10) begin miscompares++; $display("FAIL midreset.fresh_job got %0d exp 10", r); end
  endtask

  task automatic test_random();
    int r, l, rc, e, n, gap, stall; bit as, os, ba, to;
    for (int j = 0; j < 20; j++) begin
      n = int'($urandom_range(0, 6)); gap = int'($urandom_range(0, 2)); stall = int'($urandom_range(0, 3));
      gx.delete(); gw.delete();
      for (int g = 0; g < n; g++) begin gx.push_back(16'($urandom)); gw.push_back(16'($urandom)); end
      e = ref_dot();
      run_job(n, gap, stall, 0, r, l, rc, as, os, ba, to);
      vectors++;
      if (to || r != e || l != exp_lat(n, gap) || rc != exp_ready(n, gap) || !as || !os || ba !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d] n=%0d gap=%0d got r=%0d lat=%0d rdy=%0d acc=%b out=%b busy=%b exp r=%0d lat=%0d rdy=%0d",
                 j, n, gap, r, l, rc, as, os, ba, e, exp_lat(n, gap), exp_ready(n, gap));
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; out_ready = 0;
    num_groups = '0; x_in = '0; w_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero_and_ignored_start();
    test_wrap();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
